// File: rtl/carregador_de_instrucoes.sv
// rtl/carregador_de_instrucoes.sv - boot-time loader: length-prefixed byte image to instruction memory words
// Optional feature macro: CARREGADOR_CHECKSUM_EN (trailing XOR checksum byte)
module carregador_de_instrucoes #(
  parameter int RAM_SIZE = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] addr,
  output logic [31:0] datain,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_BYTES, S_WRITE, S_CHECK, S_FINISH, S_ERROR
  } state_t;

  localparam logic [15:0] MAX_WORDS = 16'(RAM_SIZE);

  // Where the image goes once the last data word (or an empty length) is seen
`ifdef CARREGADOR_CHECKSUM_EN
  localparam state_t LAST_STATE = S_CHECK;
`else
  localparam state_t LAST_STATE = S_FINISH;
`endif

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] n_words;
  logic [15:0] k;
  logic [1:0]  bcnt;
  logic [23:0] shreg;
`ifdef CARREGADOR_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  logic        hs;
  logic [15:0] n_next;

  // Byte acceptance is decoded straight from the state so a stalled source sees it immediately
  always_comb begin
    byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                 (state == S_BYTES)  || (state == S_CHECK);
  end

  assign hs       = byte_valid && byte_ready;
  assign n_next   = {len_hi, byte_data};
  assign cpu_hold = busy;

  // Loader FSM with registered memory port and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      len_hi  <= '0;
      n_words <= '0;
      k       <= '0;
      bcnt    <= '0;
      shreg   <= '0;
      we      <= 1'b0;
      addr    <= '0;
      datain  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
`ifdef CARREGADOR_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LEN_HI;
            busy  <= 1'b1;
            done  <= 1'b0;
            error <= 1'b0;
            k     <= '0;
            bcnt  <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
            csum  <= '0;
`endif
          end
        end
        S_LEN_HI: begin
          if (hs) begin
            len_hi <= byte_data;
`ifdef CARREGADOR_CHECKSUM_EN
            csum   <= csum ^ byte_data;
`endif
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (hs) begin
            n_words <= n_next;
`ifdef CARREGADOR_CHECKSUM_EN
            csum    <= csum ^ byte_data;
`endif
            if (n_next > MAX_WORDS) begin
              state <= S_ERROR;
            end else if (n_next == 16'd0) begin
              state <= LAST_STATE;
            end else begin
              state <= S_BYTES;
            end
          end
        end
        S_BYTES: begin
          if (hs) begin
            shreg <= {shreg[15:0], byte_data};
            bcnt  <= bcnt + 2'd1;
`ifdef CARREGADOR_CHECKSUM_EN
            csum  <= csum ^ byte_data;
`endif
            // Fourth byte completes the big-endian word; present it to memory next cycle
            if (bcnt == 2'd3) begin
              we     <= 1'b1;
              addr   <= {16'd0, k};
              datain <= {shreg, byte_data};
              state  <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          we <= 1'b0;
          k  <= k + 16'd1;
          if (k + 16'd1 == n_words) begin
            state <= LAST_STATE;
          end else begin
            state <= S_BYTES;
          end
        end
        S_CHECK: begin
`ifdef CARREGADOR_CHECKSUM_EN
          if (hs) begin
            state <= (byte_data == csum) ? S_FINISH : S_ERROR;
          end
`else
          state <= S_IDLE;
`endif
        end
        S_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERROR: begin
          error <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/carregador_de_instrucoes.md
# carregador_de_instrucoes

Boot-time program loader that writes the instruction memory. It accepts a byte stream from a host link (UART receiver or testbench) over a valid/ready handshake and parses a length-prefixed image. It assembles big-endian 32-bit words and drives the instruction memory write port (`we`, `addr`, `datain`) one word per write. It holds the CPU (`cpu_hold`) until the image is complete.

## Interface
- `RAM_SIZE`, 500: instruction memory depth in words; the largest image accepted.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  single-cycle pulse that begins a load; ignored while `busy`=1.
- `byte_valid`  input  1  `byte_data` is valid this cycle.
- `byte_data`  input  8  stream byte.
- `byte_ready`  output  1  loader accepts a byte this cycle.
- `we`  output  1  memory write enable; one-cycle pulse per word.
- `addr`  output  32  memory word address.
- `datain`  output  32  word to memory.
- `busy`  output  1  a load is in progress.
- `done`  output  1  load completed without error; sticky until the next accepted `start`.
- `error`  output  1  load aborted; sticky until the next accepted `start`.
- `cpu_hold`  output  1  stalls the CPU PC; equals `busy`.

## Operation
- Image format: `LEN_HI`, `LEN_LO` (N = 16-bit word count, big-endian), then 4·N data bytes. Each word is big-endian: the first byte goes to `datain[31:24]`. Word k is written to `addr` = k.
- A byte is consumed only on a rising edge where `byte_valid`=1 and `byte_ready`=1.
- States:
  - IDLE: `busy`=0, `byte_ready`=0. On `start`, clear `done`/`error`, clear the word and byte counters, and go to LEN_HI.
  - LEN_HI: `byte_ready`=1. On a handshake, latch N[15:8] and go to LEN_LO.
  - LEN_LO: `byte_ready`=1. On a handshake, latch N[7:0], then:
    - if N > `RAM_SIZE`, go to ERROR;
    - else if N = 0, go to FINISH;
    - else go to BYTES.
  - BYTES: `byte_ready`=1. Shift each byte into the assembly register. After the 4th byte, go to WRITE.
  - WRITE: `byte_ready`=0. Drive `we`=1, `addr`=k and `datain`=assembled word for exactly one cycle. Then k←k+1. If k+1 = N, go to FINISH; otherwise go to BYTES.
  - FINISH: set `done`=1 and go to IDLE.
  - ERROR: set `error`=1 and go to IDLE. No write is issued for the rejected image.
- Counters:
  - k is 16 bits; `addr` = zero-extended k.
  - N = `RAM_SIZE` is legal; the last address written is `RAM_SIZE`-1.
- `start` while `busy`=1 has no effect. `byte_valid` in IDLE is ignored and the byte is not consumed.
- Reset (asynchronous, any state, including mid-word or during WRITE):
  - state returns to IDLE;
  - `we`, `byte_ready`, `busy`, `cpu_hold`, `done` and `error` all go to 0;
  - `addr`=0, `datain`=0, counters cleared.
  - Partially loaded memory contents are left as written.

## Timing
- All outputs are registered, except `byte_ready`, which is decoded from the current state.
- Minimum cycles per word: 4 handshake cycles plus 1 WRITE cycle. `we` is never asserted on consecutive cycles.
- `done`/`error` rise one cycle after the final WRITE (or after LEN_LO / the checksum byte).
- `busy` rises the cycle after `start` is sampled and falls in the same cycle that `done` or `error` rises.
- `datain`/`addr` hold their last values after `we` deasserts.
- Source stalls (`byte_valid`=0) of any length are tolerated in every byte-accepting state.

## Configuration
- `CARREGADOR_CHECKSUM_EN` defined:
  - After the last data byte (or after LEN_LO when N=0), a CHECK state accepts one more byte.
  - The expected value is the XOR of `LEN_HI`, `LEN_LO` and all data bytes.
  - On a match, go to FINISH; on a mismatch, go to ERROR.
  - Words already written stay written.
- Undefined: there is no CHECK state, and the image ends after its data bytes.

## Test plan
- Reset mid-load: N=3, assert `rst_n`=0 after 6 data bytes → all outputs 0 immediately, state IDLE; a following `start` plus a full image loads correctly from `addr` 0.
- Basic load: `start`, bytes 00 02 DE AD BE EF 01 02 03 04 → `we` pulses twice with (0, DEADBEEF) then (1, 01020304); `done`=1, `busy`=0.
- Throttled source: same image with `byte_valid` low for 3 cycles between bytes → identical writes, and no byte is duplicated or lost.
- Empty and oversize images:
  - N=0 → `done`=1 with no `we` pulse.
  - N=501 (01 F5) with `RAM_SIZE`=500 → `error`=1 with no `we` pulse.
- Boundary: N=500 → the last write is at `addr`=499, then `done`=1; a `start` pulse mid-load is ignored.
- With `CARREGADOR_CHECKSUM_EN`:
  - image 00 01 12 34 56 78 plus checksum byte 09 → `done`=1;
  - same image with checksum byte 00 → the write at `addr` 0 occurs, then `error`=1.
